// File: rtl/moore_control_n.sv
// Parametrised Moore sequence controller: inputI edges start/pause/resume a stepping
// sequence, inputS picks direction, outputB shows a one-hot ring or binary count.
module moore_control_n #(
   parameter int WIDTH   = 4,
   parameter int DWELL   = 2,
   parameter int MODE    = 0,
   parameter int ONESHOT = 0
) (
   input  logic             inputClk,
   input  logic             inputReset,
   input  logic             inputI,
   input  logic             inputS,
   output logic [WIDTH-1:0] outputB,
   output logic [1:0]       outputState
);

   localparam int SW = (MODE == 1) ? WIDTH : ((WIDTH > 1) ? $clog2(WIDTH) : 1);
   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [SW-1:0] LAST_STEP  = (MODE == 1) ? {SW{1'b1}} : SW'(WIDTH - 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10
   } state_t;

   state_t           state_q;
   logic [SW-1:0]    step_q;
   logic [DW-1:0]    dwell_q;
   logic             i_prev_q;
   logic [WIDTH-1:0] b_q;

   logic             edge_i;
   logic [SW-1:0]    step_d;
   logic             wrap_d;

   function automatic logic [WIDTH-1:0] pattern(input logic [SW-1:0] s);
      if (MODE == 1) return WIDTH'(s);
      else           return WIDTH'(1) << s;
   endfunction

   // Candidate next step for an advance; only committed when the dwell expires.
   always_comb begin
      edge_i = inputI & ~i_prev_q;
      step_d = step_q;
      wrap_d = 1'b0;
      if (inputS) begin
         wrap_d = (step_q == '0);
         step_d = wrap_d ? LAST_STEP : step_q - SW'(1);
      end else begin
         wrap_d = (step_q == LAST_STEP);
         step_d = wrap_d ? '0 : step_q + SW'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge inputClk) begin
      if (inputReset) begin
         state_q  <= S_IDLE;
         step_q   <= '0;
         dwell_q  <= '0;
         b_q      <= '0;
         i_prev_q <= 1'b1;   // inputI held high through reset must not count as an edge
      end else begin
         i_prev_q <= inputI;
         case (state_q)
            S_IDLE: begin
               if (edge_i) begin
                  state_q <= S_RUN;
                  step_q  <= '0;
                  dwell_q <= '0;
                  b_q     <= pattern('0);
               end
            end
            S_RUN: begin
               if (edge_i) begin
                  state_q <= S_PAUSE;    // pause wins over a coincident advance
               end else if (dwell_q == DWELL_LAST) begin
                  dwell_q <= '0;
                  if (wrap_d && (ONESHOT != 0)) begin
                     state_q <= S_IDLE;
                     step_q  <= '0;
                     b_q     <= '0;
                  end else begin
                     step_q <= step_d;
                     b_q    <= pattern(step_d);
                  end
               end else begin
                  dwell_q <= dwell_q + DW'(1);
               end
            end
            S_PAUSE: begin
               if (edge_i) state_q <= S_RUN;
            end
            default: begin
               state_q <= S_IDLE;
               step_q  <= '0;
               dwell_q <= '0;
               b_q     <= '0;
            end
         endcase
      end
   end

   assign outputB     = b_q;
   assign outputState = state_q;

endmodule

// File: tb/tb_moore_control_n.sv
// Directed bench: dut0 is the default ring configuration, dut1 is binary one-shot
// with single-cycle dwell; both share the same stimulus.
module tb_moore_control_n;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_i;
   logic       in_s;
   logic [3:0] b0, b1;
   logic [1:0] st0, st1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   moore_control_n #(.WIDTH(4), .DWELL(2), .MODE(0), .ONESHOT(0)) dut0 (
      .inputClk(clk), .inputReset(rst), .inputI(in_i), .inputS(in_s),
      .outputB(b0), .outputState(st0)
   );

   moore_control_n #(.WIDTH(4), .DWELL(1), .MODE(1), .ONESHOT(1)) dut1 (
      .inputClk(clk), .inputReset(rst), .inputI(in_i), .inputS(in_s),
      .outputB(b1), .outputState(st1)
   );

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset(input logic s);
      rst  = 1'b1;
      in_i = 1'b0;
      in_s = s;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic pulse_i();
      in_i = 1'b1;
      tick();
      in_i = 1'b0;
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      in_i = 1'b0;
      in_s = 1'b0;
      tick();
      tick();
      checks++;
      if (st0 !== 2'b00 || b0 !== 4'b0000) begin
         failures++;
         $display("FAIL reset_dut0 state=%b b=%b expected state=00 b=0000", st0, b0);
      end
      checks++;
      if (st1 !== 2'b00 || b1 !== 4'b0000) begin
         failures++;
         $display("FAIL reset_dut1 state=%b b=%b expected state=00 b=0000", st1, b1);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_ring_up();
      logic [3:0] exp_b [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset(1'b0);
      pulse_i();
      checks++;
      if (st0 !== 2'b01) begin
         failures++;
         $display("FAIL ring_up_state got=%b expected=01", st0);
      end
      for (int i = 0; i < 5; i++) begin
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (b0 !== exp_b[i]) begin
               failures++;
               $display("FAIL ring_up step=%0d cyc=%0d got=%b expected=%b", i, d, b0, exp_b[i]);
            end
            tick();
         end
      end
   endtask

   task automatic test_ring_down();
      logic [3:0] exp_b [5] = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
      do_reset(1'b1);
      pulse_i();
      for (int i = 0; i < 5; i++) begin
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (b0 !== exp_b[i] || st0 !== 2'b01) begin
               failures++;
               $display("FAIL ring_down step=%0d cyc=%0d got b=%b st=%b expected b=%b st=01",
                        i, d, b0, st0, exp_b[i]);
            end
            tick();
         end
      end
   endtask

   task automatic test_binary_oneshot();
      do_reset(1'b0);
      pulse_i();
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (b1 !== 4'(i) || st1 !== 2'b01) begin
            failures++;
            $display("FAIL bin_count i=%0d got b=%b st=%b expected b=%b st=01", i, b1, st1, 4'(i));
         end
         tick();
      end
      checks++;
      if (b1 !== 4'b0000 || st1 !== 2'b00) begin
         failures++;
         $display("FAIL bin_oneshot_wrap got b=%b st=%b expected b=0000 st=00", b1, st1);
      end
   endtask

   task automatic test_pause_resume();
      do_reset(1'b0);
      pulse_i();
      repeat (4) tick();   // now at first cycle of 0100, dwell=0
      checks++;
      if (b0 !== 4'b0100) begin
         failures++;
         $display("FAIL pause_setup got=%b expected=0100", b0);
      end
      pulse_i();
      for (int c = 0; c < 10; c++) begin
         checks++;
         if (st0 !== 2'b10 || b0 !== 4'b0100) begin
            failures++;
            $display("FAIL pause_hold cyc=%0d got st=%b b=%b expected st=10 b=0100", c, st0, b0);
         end
         tick();
      end
      pulse_i();
      // frozen dwell=0: two more cycles at 0100, then 1000
      checks++;
      if (st0 !== 2'b01 || b0 !== 4'b0100) begin
         failures++;
         $display("FAIL resume_first got st=%b b=%b expected st=01 b=0100", st0, b0);
      end
      tick();
      checks++;
      if (b0 !== 4'b0100) begin
         failures++;
         $display("FAIL resume_second got=%b expected=0100", b0);
      end
      tick();
      checks++;
      if (b0 !== 4'b1000) begin
         failures++;
         $display("FAIL resume_advance got=%b expected=1000", b0);
      end
   endtask

   task automatic test_held_through_reset();
      rst  = 1'b1;
      in_i = 1'b1;
      in_s = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      repeat (3) tick();
      checks++;
      if (st0 !== 2'b00 || b0 !== 4'b0000) begin
         failures++;
         $display("FAIL held_high_idle got st=%b b=%b expected st=00 b=0000", st0, b0);
      end
      in_i = 1'b0;
      tick();
      pulse_i();
      checks++;
      if (st0 !== 2'b01 || b0 !== 4'b0001) begin
         failures++;
         $display("FAIL held_high_restart got st=%b b=%b expected st=01 b=0001", st0, b0);
      end
   endtask

   task automatic test_reset_in_run();
      do_reset(1'b0);
      pulse_i();
      repeat (6) tick();
      checks++;
      if (b0 !== 4'b1000) begin
         failures++;
         $display("FAIL run_reset_setup got=%b expected=1000", b0);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (st0 !== 2'b00 || b0 !== 4'b0000) begin
         failures++;
         $display("FAIL run_reset got st=%b b=%b expected st=00 b=0000", st0, b0);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      do_reset(1'b0);
      pulse_i();
      tick();              // second cycle of 0001, dwell=DWELL-1
      pulse_i();           // edge coincides with the advance
      checks++;
      if (st0 !== 2'b10 || b0 !== 4'b0001) begin
         failures++;
         $display("FAIL coincide_pause got st=%b b=%b expected st=10 b=0001", st0, b0);
      end
      tick();
      checks++;
      if (st0 !== 2'b10 || b0 !== 4'b0001) begin
         failures++;
         $display("FAIL coincide_hold got st=%b b=%b expected st=10 b=0001", st0, b0);
      end
      pulse_i();
      checks++;
      if (st0 !== 2'b01 || b0 !== 4'b0001) begin
         failures++;
         $display("FAIL coincide_resume got st=%b b=%b expected st=01 b=0001", st0, b0);
      end
      tick();
      checks++;
      if (b0 !== 4'b0010) begin
         failures++;
         $display("FAIL coincide_advance got=%b expected=0010", b0);
      end
   endtask

   initial begin
      rst  = 1'b1;
      in_i = 1'b0;
      in_s = 1'b0;
      test_reset();
      test_ring_up();
      test_ring_down();
      test_binary_oneshot();
      test_pause_resume();
      test_held_through_reset();
      test_reset_in_run();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/moore_control_n.md
Name: moore_control_n

Overview:
Parametrised Moore sequence controller, the N-bit successor of the two-output control block.
- A rising edge on inputI starts, pauses and resumes a stepping sequence.
- inputS selects the step direction.
- outputB drives WIDTH channels, either one-hot ring or binary count.
- All outputs are registered and depend only on state, never on current inputs.

Parameters:
WIDTH, 4, number of output channels (>=2)
DWELL, 2, clock cycles spent on each step in RUN (>=1)
MODE, 0, 0 = one-hot ring pattern, 1 = binary count pattern
ONESHOT, 0, 0 = wrap and continue, 1 = return to IDLE on wrap

Ports:
inputClk  input  1  system clock, rising-edge active
inputReset  input  1  synchronous, active-high reset
inputI  input  1  start/pause/resume request, edge-sensitive
inputS  input  1  direction: 0 = up, 1 = down, level-sampled
outputB  output  WIDTH  channel pattern
outputState  output  2  current state: IDLE=00, RUN=01, PAUSE=10

Behaviour:
- Interface: one clock, inputClk. Reset inputReset is synchronous and active-high.
- Reset, sampled on a rising edge:
  - state=IDLE, outputB=0, outputState=00, step=0, dwell counter=0.
  - Edge register iPrev is set to 1, so inputI held high through reset release gives no edge.
- Reset dominates every other event, including mid-RUN and mid-PAUSE.
- Edge detection:
  - edgeI is true at clock edge k when inputI=1 at k and iPrev=0.
  - iPrev <= inputI every cycle.
  - The state update happens at that same edge k, so it is visible one cycle after inputI rises.
- Pattern function:
  - MODE 0: outputB = 1 << step, with step in 0..WIDTH-1.
  - MODE 1: outputB = step, with step in 0..2^WIDTH-1.
  - The step register width is $clog2(WIDTH) for MODE 0 and WIDTH for MODE 1.
- IDLE:
  - outputB=0.
  - edgeI -> RUN, step=0, dwell=0.
  - outputB = pattern(0) right after edge k (0001 in MODE 0, 0000 in MODE 1).
- RUN:
  - The dwell counter increments each cycle.
  - When dwell=DWELL-1: dwell <= 0 and step advances, +1 if inputS=0 or -1 if inputS=1.
  - inputS is sampled only on the advancing edge.
  - Each step is therefore held exactly DWELL cycles.
  - edgeI -> PAUSE. Dwell and step freeze, outputB holds.
- PAUSE:
  - outputB and counters hold.
  - edgeI -> RUN, resuming from the frozen dwell value (not restarting it).
- Wrap:
  - Upward: last step -> 0. Downward: 0 -> last step. The last step is WIDTH-1 (MODE 0) or 2^WIDTH-1 (MODE 1).
  - ONESHOT=0: continue in RUN.
  - ONESHOT=1: a wrapping advance goes to IDLE instead (outputB=0, step=0).
- Simultaneous events:
  - edgeI on the same edge as an advance in RUN: PAUSE wins, no advance, dwell frozen at DWELL-1.
  - On resume, the advance happens on the first RUN edge.
- inputS changes between advances have no effect.
- No illegal-state lockup: an encoding of 11 returns to IDLE on the next edge.

Test Plan:
1. WIDTH=4, DWELL=2, MODE=0. Reset, then pulse inputI high for one cycle, inputS=0 -> outputState=01, outputB=0001 for 2 cycles, then 0010, 0100, 1000, 0001 (wrap), each held 2 cycles.
2. Same config with inputS=1 from start -> outputB sequence 0001, 1000, 0100, 0010, 0001, each held 2 cycles.
3. MODE=1, DWELL=1, ONESHOT=1, inputS=0 -> outputB counts 0,1,...,15 one per cycle; the next edge gives outputState=00, outputB=0.
4. RUN at outputB=0100, pulse inputI -> outputState=10 and outputB=0100 held for 10 cycles. Pulse inputI again -> RUN resumes and the next advance occurs after the remaining dwell.
5. inputI held high across reset deassertion -> stays IDLE, outputB=0. Dropping and re-raising inputI then starts RUN.
6. Assert inputReset in RUN at outputB=1000 -> next edge gives outputState=00, outputB=0000. inputI edge coincident with an advance -> PAUSE, outputB unchanged.
